shift_add_multiplier_16bit: RTL and testbench

Sequential unsigned 16x16 -> 32-bit multiplier. Sits directly downstream of ripple_carry_adder_16bit in the computation path: it uses one adder instance per iteration and consumes its sum/cout each cycle. It is the first multi-cycle arithmetic unit in computation/, controlled by a start/busy/done handshake.

---
 rtl/shift_add_multiplier_16bit_pkg.sv | 16 +
 rtl/ripple_carry_adder_16bit.sv | 23 ++
 rtl/shift_add_multiplier_16bit.sv | 99 +++++++++
 tb/tb_shift_add_multiplier_16bit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_16bit_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package shift_add_multiplier_16bit_pkg;

  localparam int unsigned MUL_W    = 16;
  localparam int unsigned MUL_ITER = 16;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned PROD_W   = 2 * MUL_W;

  // 2'd3 is unused and falls back to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_adder_16bit.sv
// 16-bit ripple-carry adder with carry in/out.
module ripple_carry_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic carry;

  // Bit-serial carry propagation, LSB first
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_multiplier_16bit.sv
// Unsigned 16x16 -> 32 sequential multiplier: one conditional add and right shift
// per cycle, 16 iterations, start/busy/done handshake.
module shift_add_multiplier_16bit
  import shift_add_multiplier_16bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t             state;
  logic [MUL_W-1:0]   mcand;
  logic [MUL_W-1:0]   acc_hi;
  logic [MUL_W-1:0]   acc_lo;
  logic [CNT_W-1:0]   count;
  logic [MUL_W-1:0]   sum;
  logic               cout;
  logic [MUL_W-1:0]   nxt_hi;
  logic [MUL_W-1:0]   nxt_lo;

  ripple_carry_adder_16bit u_adder (
    .a    (acc_hi),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Post-shift accumulator; adder carry lands in the MSB so nothing is lost
  always_comb begin
    nxt_hi = {1'b0, acc_hi[MUL_W-1:1]};
    nxt_lo = {acc_hi[0], acc_lo[MUL_W-1:1]};
    if (acc_lo[0]) begin
      nxt_hi = {cout, sum[MUL_W-1:1]};
      nxt_lo = {sum[0], acc_lo[MUL_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          count  <= count + CNT_W'(1);
          if (count == CNT_W'(MUL_ITER - 1)) begin
            product <= {nxt_hi, nxt_lo};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Back-to-back accept keeps throughput at one result per 17 cycles
          if (start) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier_16bit.sv
// Directed self-checking bench for shift_add_multiplier_16bit.
module tb_shift_add_multiplier_16bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int passed = 0;
  int total  = 0;

  shift_add_multiplier_16bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Ticks until done is seen (bounded); reports cycles waited and busy-high samples
  task automatic wait_done(output int n, output int bcount);
    n = 0;
    bcount = 0;
    while (!done && n < 40) begin
      if (busy) bcount++;
      tick();
      n++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) pulses++;
    end
  endtask

  int n, bc, pulses;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", product, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic 3*5
    start = 1'b1; a = 16'd3; b = 16'd5;
    tick();
    start = 1'b0;
    chk("basic_busy_after_accept", 32'(busy), 32'd1);
    wait_done(n, bc);
    chk("basic_latency", 32'(n), 32'd16);
    chk("basic_busy_cycles", 32'(bc), 32'd16);
    chk("basic_busy_in_done", 32'(busy), 32'd0);
    chk("basic_product", product, 32'h0000_000F);
    tick();
    chk("basic_done_one_cycle", 32'(done), 32'd0);
    chk("basic_product_held", product, 32'h0000_000F);

    // Max operands
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    tick();
    start = 1'b0; a = 16'h0; b = 16'h0;
    tick(); tick(); tick();
    chk("max_product_held_in_run", product, 32'h0000_000F);
    wait_done(n, bc);
    chk("max_latency", 32'(n), 32'd13);
    chk("max_product", product, 32'hFFFE_0001);
    tick();

    // Zero multiplicand
    start = 1'b1; a = 16'h0000; b = 16'h1234;
    tick();
    start = 1'b0;
    wait_done(n, bc);
    chk("zero_product", product, 32'h0000_0000);
    tick();

    // Identity, product must hold zero while running
    start = 1'b1; a = 16'h1234; b = 16'h0001;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("ident_product_held_in_run", product, 32'h0000_0000);
    wait_done(n, bc);
    chk("ident_product", product, 32'h0000_1234);
    tick();

    // start during RUN is ignored; operand changes do not matter
    start = 1'b1; a = 16'd7; b = 16'd9;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    tick();
    start = 1'b0; a = 16'h5A5A; b = 16'hA5A5;
    wait_done(n, bc);
    chk("ignore_latency", 32'(n), 32'd11);
    chk("ignore_product", product, 32'h0000_003F);
    count_done(20, pulses);
    chk("ignore_no_extra_done", 32'(pulses), 32'd0);
    chk("ignore_idle_busy", 32'(busy), 32'd0);

    // Back-to-back with start held high
    start = 1'b1; a = 16'h8000; b = 16'h0002;
    tick();
    chk("b2b_busy_first", 32'(busy), 32'd1);
    wait_done(n, bc);
    chk("b2b_first_latency", 32'(n), 32'd16);
    chk("b2b_first_busy_cycles", 32'(bc), 32'd16);
    chk("b2b_first_product", product, 32'h0001_0000);
    a = 16'h00FF; b = 16'h0100;
    tick();
    chk("b2b_reaccept_busy", 32'(busy), 32'd1);
    chk("b2b_reaccept_done_low", 32'(done), 32'd0);
    wait_done(n, bc);
    chk("b2b_second_spacing", 32'(n + 1), 32'd17);
    chk("b2b_second_busy_cycles", 32'(bc), 32'd16);
    chk("b2b_second_product", product, 32'h0000_FF00);
    start = 1'b0;
    tick();
    chk("b2b_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of an operation
    start = 1'b1; a = 16'd3; b = 16'd5;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_product", product, 32'h0000_0000);
    tick(); tick();
    rst = 1'b0;
    count_done(25, pulses);
    chk("rst_no_done_after", 32'(pulses), 32'd0);
    chk("rst_product_stays_zero", product, 32'h0000_0000);
    start = 1'b1; a = 16'h00AB; b = 16'h0CD0;
    tick();
    start = 1'b0;
    wait_done(n, bc);
    chk("post_rst_latency", 32'(n), 32'd16);
    chk("post_rst_product", product, 32'h0008_8EF0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
